// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants for the streaming Sobel edge filter
// Contents: luma weights and shift, output mode encodings, pipeline latency.
package sobel_pkg;

    // Y = (54*R + 183*G + 18*B) >> 8; weights sum to 255 so Y never overflows
    localparam int LUMA_KR    = 54;
    localparam int LUMA_KG    = 183;
    localparam int LUMA_KB    = 18;
    localparam int LUMA_SHIFT = 8;

    // Output modes; encoding 3 behaves like MODE_MAG
    localparam logic [1:0] MODE_MAG  = 2'd0;
    localparam logic [1:0] MODE_BIN  = 2'd1;
    localparam logic [1:0] MODE_LUMA = 2'd2;

    // Clock edges from accepted input pixel to its output pixel
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one-line luma RAM, single address, read-before-write
// Ports:
//   clk      - pixel clock
//   en       - access strobe (accepted pixel): registers the old word, writes wdata
//   addr     - column address
//   wdata    - word written at addr
//   rdata    - registered pre-write word from the last access
//   cur_data - pre-write word at addr this cycle, used to cascade into the next line
// The array is deliberately not reset; stale words are masked downstream.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] cur_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign cur_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming RGB-to-luma Sobel edge filter, 3-cycle latency
// Ports:
//   clk, rst_n             - pixel clock, asynchronous active-low reset
//   in_valid, in_sof       - pixel qualifier (gaps allowed), first pixel of frame
//   in_r, in_g, in_b       - colour channels
//   thresh, mode           - edge threshold and output mode, captured at accepted in_sof
//   out_valid, out_sof     - output qualifier and frame start, 3 edges after input
//   out_pix                - magnitude / binary / luma result, held while out_valid=0
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    input  logic [PIX_W-1:0] thresh,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic             out_sof,
    output logic [PIX_W-1:0] out_pix
);

    localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int GW    = PIX_W + 3;
    localparam int LW    = PIX_W + 8;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    function automatic logic signed [GW-1:0] sext(input logic [PIX_W-1:0] v);
        return signed'(GW'(v));
    endfunction

    // Position of the incoming pixel: an accepted in_sof restarts at (0,0)
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic [LW-1:0]    luma_sum;
    logic [PIX_W-1:0] luma;

    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        luma_sum = LW'(LUMA_KR) * LW'(in_r) + LW'(LUMA_KG) * LW'(in_g)
                 + LW'(LUMA_KB) * LW'(in_b);
        luma     = PIX_W'(luma_sum >> LUMA_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_MAX) ? cur_row : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // lb0 holds line y-1; its pre-write word cascades into lb1 (line y-2)
    logic [PIX_W-1:0] lb0_rd, lb1_rd, lb0_cur, lb1_cur;
    logic             unused_lb1_cur;

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(LB_AW)) u_lb0 (
        .clk(clk), .en(in_valid), .addr(cur_col[LB_AW-1:0]),
        .wdata(luma), .rdata(lb0_rd), .cur_data(lb0_cur)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(LB_AW)) u_lb1 (
        .clk(clk), .en(in_valid), .addr(cur_col[LB_AW-1:0]),
        .wdata(lb0_cur), .rdata(lb1_rd), .cur_data(lb1_cur)
    );

    // lb1 is the end of the cascade, so its pre-write word has no consumer
    assign unused_lb1_cur = ^lb1_cur;

    // Stage 1: luma, sof, border flag, and the per-frame settings this pixel uses
    logic [PIX_W-1:0] mode_thr_dummy;
    logic [PIX_W-1:0] thresh_q, thresh_s1, thresh_s2;
    logic [1:0]       mode_q, mode_s1, mode_s2;
    logic [PIX_W-1:0] y_s1;
    logic             v_s1, sof_s1, border_s1;

    assign mode_thr_dummy = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1      <= 1'b0;
            sof_s1    <= 1'b0;
            border_s1 <= 1'b0;
            y_s1      <= '0;
            thresh_q  <= '0;
            mode_q    <= '0;
            thresh_s1 <= '0;
            mode_s1   <= '0;
        end else begin
            v_s1   <= in_valid;
            sof_s1 <= in_valid & in_sof;
            if (in_valid) begin
                y_s1      <= luma;
                border_s1 <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
                if (in_sof) begin
                    thresh_q <= thresh;
                    mode_q   <= mode;
                end
                // Carrying the settings with the pixel keeps the tail of the
                // previous frame on its own settings after a new in_sof
                thresh_s1 <= in_sof ? thresh : thresh_q;
                mode_s1   <= in_sof ? mode : mode_q;
            end
        end
    end

    // Stage 2: 3x3 window (p0..p8 row-major, p4 centre) and gradients
    logic [PIX_W-1:0]     win [9];
    logic [PIX_W-1:0]     nwin [9];
    logic signed [GW-1:0] gx_n, gy_n, gx_s2, gy_s2;
    logic                 v_s2, sof_s2, border_s2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nwin[3*i]     = win[3*i + 1];
            nwin[3*i + 1] = win[3*i + 2];
        end
        nwin[2] = lb1_rd;
        nwin[5] = lb0_rd;
        nwin[8] = y_s1;
        gx_n = (sext(nwin[2]) - sext(nwin[0])) + ((sext(nwin[5]) - sext(nwin[3])) <<< 1)
             + (sext(nwin[8]) - sext(nwin[6]));
        gy_n = (sext(nwin[0]) - sext(nwin[6])) + ((sext(nwin[1]) - sext(nwin[7])) <<< 1)
             + (sext(nwin[2]) - sext(nwin[8]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            gx_s2     <= '0;
            gy_s2     <= '0;
            v_s2      <= 1'b0;
            sof_s2    <= 1'b0;
            border_s2 <= 1'b0;
            thresh_s2 <= '0;
            mode_s2   <= '0;
        end else begin
            v_s2   <= v_s1;
            sof_s2 <= sof_s1;
            if (v_s1) begin
                for (int i = 0; i < 9; i++) win[i] <= nwin[i];
                gx_s2     <= gx_n;
                gy_s2     <= gy_n;
                border_s2 <= border_s1;
                thresh_s2 <= thresh_s1;
                mode_s2   <= mode_s1;
            end
        end
    end

    // Stage 3: magnitude, threshold, mode select, border mask
    logic [GW-1:0]    abs_gx, abs_gy, mag;
    logic [PIX_W-1:0] mag_sat, res;
    logic             hit;

    always_comb begin
        abs_gx  = gx_s2[GW-1] ? GW'(-gx_s2) : GW'(gx_s2);
        abs_gy  = gy_s2[GW-1] ? GW'(-gy_s2) : GW'(gy_s2);
        mag     = abs_gx + abs_gy;
        mag_sat = (mag > GW'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
        hit     = mag > GW'(thresh_s2);
        res     = mode_thr_dummy;
        if (mode_s2 == MODE_LUMA)
            res = win[4];
        else if (border_s2)
            res = '0;
        else if (mode_s2 == MODE_BIN)
            res = hit ? PIX_MAX : '0;
        else
            res = hit ? mag_sat : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_pix   <= '0;
        end else begin
            out_valid <= v_s2;
            out_sof   <= sof_s2;
            if (v_s2) out_pix <= res;
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - self-checking bench for sobel_stream_filter
module tb_sobel_stream_filter;
    import sobel_pkg::*;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_sof;
    logic [7:0] in_r, in_g, in_b, thresh;
    logic [1:0] mode;
    logic       out_valid, out_sof;
    logic [7:0] out_pix;

    sobel_stream_filter #(.IMG_W(W), .PIX_W(8), .COL_W(4), .ROW_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .thresh(thresh), .mode(mode),
        .out_valid(out_valid), .out_sof(out_sof), .out_pix(out_pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        bit         care;
        int         acc_edge;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    int   lum [16][W];
    int   cur_mode, cur_th;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard check of every output pixel
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: out_valid=1 pix=%0d, required no output", out_pix);
            end else begin
                mon_e = sb.pop_front();
                if (edge_cnt - mon_e.acc_edge + 1 != PIPE_LAT) begin
                    n_err++;
                    $display("FAIL latency: got %0d edges, required %0d", edge_cnt - mon_e.acc_edge + 1, PIPE_LAT);
                end
                n_cmp++;
                if (out_sof !== mon_e.sof) begin
                    n_err++;
                    $display("FAIL out_sof: got %b, required %b", out_sof, mon_e.sof);
                end
                if (mon_e.care) begin
                    n_cmp++;
                    if (out_pix !== mon_e.pix) begin
                        n_err++;
                        $display("FAIL out_pix: got %0d, required %0d", out_pix, mon_e.pix);
                    end
                end
            end
        end
    end

    task automatic pix_color(input int kind, input int r, input int c,
                             output int rr, output int gg, output int bb);
        int g;
        case (kind)
            0:       g = 100;
            1:       g = (c < 4) ? 0 : 255;
            2:       g = 10 * c;
            default: g = -1;
        endcase
        if (g >= 0) begin
            rr = g; gg = g; bb = g;
        end else begin
            rr = (37 * c + 11 * r) % 256;
            gg = (59 * r + 23 * c + 7) % 256;
            bb = (91 * (r + c)) % 256;
        end
    endtask

    function automatic exp_t expect_at(input int r, input int c);
        exp_t e;
        int p[9];
        int gx, gy, mag, sat;
        e.care = 1'b1;
        e.pix  = 8'd0;
        e.sof  = 1'b0;
        e.acc_edge = 0;
        if (cur_mode == 2) begin
            if (r >= 1 && c >= 1) e.pix = 8'(lum[r-1][c-1]);
            else                  e.care = 1'b0;
        end else if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    p[3*i + j] = lum[r-2+i][c-2+j];
            gx  = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
            gy  = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            sat = (mag > 255) ? 255 : mag;
            if (mag > cur_th) e.pix = (cur_mode == 1) ? 8'd255 : 8'(sat);
        end
        return e;
    endfunction

    // Streams npix pixels of a frame starting with in_sof; th_mid >= 0 changes
    // the thresh input half-way without a new in_sof
    task automatic send_frame(input int kind, input int npix, input int md, input int th,
                              input int gap_pct, input int th_mid);
        int r, c, rr, gg, bb, ng;
        exp_t e;
        for (int k = 0; k < npix; k++) begin
            r = k / W;
            c = k % W;
            ng = 0;
            while (gap_pct > 0 && ng < 6 && $urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_sof   = 1'($urandom_range(1));
                in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
                ng++;
            end
            @(posedge clk); #1;
            pix_color(kind, r, c, rr, gg, bb);
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_r = 8'(rr); in_g = 8'(gg); in_b = 8'(bb);
            if (k == 0) begin
                mode = 2'(md); thresh = 8'(th);
                cur_mode = md; cur_th = th;
            end else begin
                mode = 2'(k);
                if (k == npix / 2 && th_mid >= 0) thresh = 8'(th_mid);
            end
            lum[r][c] = (54 * rr + 183 * gg + 18 * bb) >> 8;
            e = expect_at(r, c);
            e.sof = (k == 0);
            e.acc_edge = edge_cnt + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d outputs missing, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            in_sof   = in_valid;
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_sof, out_pix} !== 10'd0) begin
                n_err++;
                $display("FAIL reset_out: got v=%b s=%b p=%0d, required 0/0/0", out_valid, out_sof, out_pix);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        rst_n = 1'b1;
        // two pixels in flight, then a reset that must abort them
        send_frame(2, 2, 0, 0, 0, -1);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_sof, out_pix} !== 10'd0) begin
                n_err++;
                $display("FAIL abort_out: got v=%b s=%b p=%0d, required 0/0/0", out_valid, out_sof, out_pix);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        send_frame(2, 10, 0, 0, 0, -1);
        drain("first_frame");
    endtask

    task automatic test_flat();
        send_frame(0, 6 * W, 0, 0, 0, -1);
        drain("flat");
    endtask

    task automatic test_vstep();
        send_frame(1, 6 * W, 0, 0, 0, -1);
        drain("vstep");
    endtask

    task automatic test_ramp();
        send_frame(2, 5 * W, 0, 80, 0, -1);
        send_frame(2, 5 * W, 0, 79, 0, 200);
        send_frame(2, 5 * W, 1, 79, 0, -1);
        send_frame(2, 5 * W, 3, 50, 0, -1);
        drain("ramp");
    endtask

    task automatic test_gaps();
        send_frame(2, 5 * W, 0, 79, 30, -1);
        send_frame(3, 5 * W, 2, 0, 30, -1);
        send_frame(3, 5 * W, 0, 100, 30, -1);
        drain("gaps");
    endtask

    task automatic test_back_to_back_mid_sof();
        send_frame(3, 3 * W + 5, 2, 0, 0, -1);
        send_frame(2, 6 * W, 2, 0, 0, -1);
        drain("mid_sof");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_r = '0; in_g = '0; in_b = '0; thresh = '0; mode = '0;
        test_reset();
        test_flat();
        test_vstep();
        test_ramp();
        test_gaps();
        test_back_to_back_mid_sof();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
